// File: rtl/tap_driver.sv
// TAP initiator: serialises RESET / SHIFT / IDLE_CLOCKS commands onto tck/tdi/trstb
// and returns the captured tdo stream and tde count as a one-cycle response.
module tap_driver #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned RESET_CYCLES = 8
) (
    input  logic        gclk,
    input  logic        gclk_rstb,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_len,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic [4:0]  rsp_tde_cnt,
    output logic        tck,
    output logic        trstb,
    output logic        tdi,
    input  logic        tdo,
    input  logic        tde
);

    localparam int unsigned PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RST_LEN = 2 * CLK_DIV * RESET_CYCLES;
    localparam int unsigned RC_W    = $clog2(RST_LEN + 1);

    // HIGH is the only encoding with bit 2 set, so tck comes straight off a state flop.
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        RST  = 3'b001,
        LOW  = 3'b010,
        DONE = 3'b011,
        HIGH = 3'b110
    } state_t;

    typedef enum logic [1:0] {
        OP_RESET       = 2'd0,
        OP_SHIFT       = 2'd1,
        OP_IDLE_CLOCKS = 2'd2,
        OP_RSVD        = 2'd3
    } op_t;

    state_t            state;
    state_t            state_nx;
    op_t               op_in;
    op_t               op_q;
    logic              live;
    logic              err_q;
    logic              trstb_q;
    logic [4:0]        len_q;
    logic [15:0]       cnt_q;
    logic [15:0]       shreg;
    logic [PH_W-1:0]   ph;
    logic [4:0]        bitcnt;
    logic [15:0]       per;
    logic [RC_W-1:0]   rcnt;
    logic [15:0]       rdata_q;
    logic [4:0]        tde_cnt_q;
    logic              accept;
    logic              cmd_bad;
    logic              phase_end;
    logic              last_period;
    logic              rst_end;

    assign op_in       = op_t'(cmd_op);
    assign accept      = cmd_valid && cmd_ready;
    assign cmd_bad     = (op_in == OP_RSVD) ||
                         ((op_in == OP_SHIFT) && ((cmd_len == 5'd0) || (cmd_len > 5'd16)));
    assign phase_end   = (ph == PH_W'(CLK_DIV - 1));
    assign rst_end     = (rcnt == RC_W'(RST_LEN - 1));
    assign last_period = (op_q == OP_SHIFT) ? (bitcnt == (len_q - 5'd1))
                                            : (per == (cnt_q - 16'd1));

    always_ff @(posedge gclk) begin
        if (!gclk_rstb) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (accept) begin
                    if (cmd_bad) begin
                        state_nx = DONE;
                    end else begin
                        case (op_in)
                            OP_RESET:       state_nx = RST;
                            OP_SHIFT:       state_nx = LOW;
                            OP_IDLE_CLOCKS: state_nx = (cmd_data == 16'd0) ? DONE : LOW;
                            default:        state_nx = DONE;
                        endcase
                    end
                end
            end
            RST:     if (rst_end) state_nx = DONE;
            LOW:     if (phase_end) state_nx = HIGH;
            HIGH:    if (phase_end) state_nx = last_period ? DONE : LOW;
            default: state_nx = IDLE;
        endcase
    end

    // Payload is left-aligned so tdi is always shreg[15]; it drains to zero after the last bit.
    always_ff @(posedge gclk) begin
        if (!gclk_rstb) begin
            live      <= 1'b0;
            op_q      <= OP_RESET;
            err_q     <= 1'b0;
            trstb_q   <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            shreg     <= '0;
            ph        <= '0;
            bitcnt    <= '0;
            per       <= '0;
            rcnt      <= '0;
            rdata_q   <= '0;
            tde_cnt_q <= '0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                op_q      <= op_in;
                len_q     <= cmd_len;
                cnt_q     <= cmd_data;
                err_q     <= cmd_bad;
                rdata_q   <= '0;
                tde_cnt_q <= '0;
                ph        <= '0;
                bitcnt    <= '0;
                per       <= '0;
                rcnt      <= '0;
                shreg     <= ((op_in == OP_SHIFT) && !cmd_bad) ? (cmd_data << (5'd16 - cmd_len)) : '0;
                if ((op_in == OP_RESET) && !cmd_bad) begin
                    trstb_q <= 1'b0;
                end
            end else begin
                case (state)
                    RST: begin
                        rcnt <= rcnt + RC_W'(1);
                        if (rst_end) begin
                            trstb_q <= 1'b1;
                        end
                    end
                    LOW: begin
                        ph <= phase_end ? '0 : ph + PH_W'(1);
                    end
                    HIGH: begin
                        if (phase_end) begin
                            ph <= '0;
                            if (op_q == OP_SHIFT) begin
                                rdata_q   <= {rdata_q[14:0], tdo};
                                tde_cnt_q <= tde_cnt_q + {4'd0, tde};
                                shreg     <= {shreg[14:0], 1'b0};
                                bitcnt    <= bitcnt + 5'd1;
                            end else begin
                                per <= per + 16'd1;
                            end
                        end else begin
                            ph <= ph + PH_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        cmd_ready   = live && ((state == IDLE) || (state == DONE));
        rsp_valid   = (state == DONE);
        rsp_err     = (state == DONE) && err_q;
        rsp_data    = rdata_q;
        rsp_tde_cnt = tde_cnt_q;
        tck         = state[2];
        tdi         = shreg[15];
        trstb       = trstb_q;
    end

endmodule

// File: tb/tb_tap_driver.sv
// Directed bench for tap_driver (CLK_DIV=4, RESET_CYCLES=8): pin timing, capture,
// error responses, back-to-back handshakes and mid-command reset.
module tb_tap_driver;

    localparam int CD = 4;

    logic        gclk;
    logic        gclk_rstb;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_tde_cnt;
    logic        tck;
    logic        trstb;
    logic        tdi;
    logic        tdo;
    logic        tde;
    logic        loop_en;
    logic        tdo_fix;

    int n_chk  = 0;
    int n_fail = 0;
    int bad;
    int rises;

    assign tdo = loop_en ? tdi : tdo_fix;

    tap_driver #(.CLK_DIV(4), .RESET_CYCLES(8)) dut (
        .gclk        (gclk),
        .gclk_rstb   (gclk_rstb),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_data    (rsp_data),
        .rsp_tde_cnt (rsp_tde_cnt),
        .tck         (tck),
        .trstb       (trstb),
        .tdi         (tdi),
        .tdo         (tdo),
        .tde         (tde)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake in the current cycle; returns at the negedge of cycle 1.
    task automatic issue(input logic [1:0] op, input logic [4:0] len, input logic [15:0] data);
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        chk("handshake_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge gclk);
        cmd_valid = 1'b0;
        cmd_len   = 5'($urandom);
        cmd_data  = 16'($urandom);
    endtask

    // Walks cycles 1..n of a command, counting cycles whose pins differ from the
    // expected waveform; mode 0=RESET, 1=SHIFT, 2=IDLE_CLOCKS.
    task automatic walk(input int n, input int mode, input logic [15:0] data, input int len,
                        input logic exp_trstb, input int tde_off_bits, input logic poke,
                        output int nbad, output int nrise);
        logic prev;
        logic etck;
        logic etdi;
        int   k;
        nbad  = 0;
        nrise = 0;
        prev  = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (c > 1) @(negedge gclk);
            k    = (c - 1) / (2 * CD);
            etck = (mode != 0) && (((c - 1) % (2 * CD)) >= CD);
            etdi = 1'b0;
            if (mode == 1 && (len - 1 - k) >= 0) etdi = data[len - 1 - k];
            tde       = (k >= tde_off_bits);
            cmd_valid = poke && (c < n);
            cmd_op    = 2'd3;
            if (tck !== etck || tdi !== etdi || trstb !== exp_trstb ||
                rsp_valid !== 1'b0 || cmd_ready !== 1'b0) nbad++;
            if (tck === 1'b1 && prev === 1'b0) nrise++;
            prev = tck;
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        gclk_rstb = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_len   = 5'd0;
        cmd_data  = 16'd0;
        tde       = 1'b0;
        loop_en   = 1'b0;
        tdo_fix   = 1'b0;
        repeat (3) @(negedge gclk);

        chk("rst_tck",       {31'd0, tck},         32'd0);
        chk("rst_trstb",     {31'd0, trstb},       32'd0);
        chk("rst_tdi",       {31'd0, tdi},         32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready},   32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid},   32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},     32'd0);
        chk("rst_rsp_data",  {16'd0, rsp_data},    32'd0);
        chk("rst_tde_cnt",   {27'd0, rsp_tde_cnt}, 32'd0);

        gclk_rstb = 1'b1;
        chk("release_ready_lo", {31'd0, cmd_ready}, 32'd0);
        @(negedge gclk);
        chk("release_ready_hi", {31'd0, cmd_ready}, 32'd1);
        chk("release_trstb",    {31'd0, trstb},     32'd0);
        @(negedge gclk);

        // RESET: trstb low cycles 1..64, released with rsp_valid at 65
        issue(2'd0, 5'd0, 16'd0);
        walk(64, 0, 16'd0, 0, 1'b0, 0, 1'b0, bad, rises);
        chk("reset_window", bad,   0);
        chk("reset_rises",  rises, 0);
        @(negedge gclk);
        chk("reset_done_valid", {31'd0, rsp_valid}, 32'd1);
        chk("reset_done_err",   {31'd0, rsp_err},   32'd0);
        chk("reset_done_trstb", {31'd0, trstb},     32'd1);
        chk("reset_done_tck",   {31'd0, tck},       32'd0);
        chk("reset_done_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge gclk);
        chk("idle_no_valid", {31'd0, rsp_valid}, 32'd0);

        // SHIFT len=8 0x96 with tdo held 1, tde 1
        tdo_fix = 1'b1;
        issue(2'd1, 5'd8, 16'h0096);
        walk(64, 1, 16'h0096, 8, 1'b1, 0, 1'b0, bad, rises);
        chk("shift8_waveform", bad,   0);
        chk("shift8_rises",    rises, 8);
        @(negedge gclk);
        chk("shift8_valid",   {31'd0, rsp_valid},   32'd1);
        chk("shift8_err",     {31'd0, rsp_err},     32'd0);
        chk("shift8_data",    {16'd0, rsp_data},    32'h00FF);
        chk("shift8_tde_cnt", {27'd0, rsp_tde_cnt}, 32'd8);
        chk("shift8_tdi_done", {31'd0, tdi},        32'd0);

        // Loopback len=12 0x0BEE, back-to-back from the DONE cycle
        loop_en = 1'b1;
        issue(2'd1, 5'd12, 16'h0BEE);
        walk(96, 1, 16'h0BEE, 12, 1'b1, 0, 1'b0, bad, rises);
        chk("loop12_waveform", bad, 0);
        @(negedge gclk);
        chk("loop12_valid",   {31'd0, rsp_valid},   32'd1);
        chk("loop12_data",    {16'd0, rsp_data},    32'h0BEE);
        chk("loop12_tde_cnt", {27'd0, rsp_tde_cnt}, 32'd12);
        @(negedge gclk);
        chk("hold_data",    {16'd0, rsp_data},    32'h0BEE);

        issue(2'd1, 5'd12, 16'h0BEE);
        chk("clear_data",    {16'd0, rsp_data},    32'd0);
        chk("clear_tde_cnt", {27'd0, rsp_tde_cnt}, 32'd0);
        walk(96, 1, 16'h0BEE, 12, 1'b1, 4, 1'b0, bad, rises);
        chk("loop12b_waveform", bad, 0);
        @(negedge gclk);
        chk("loop12b_data",    {16'd0, rsp_data},    32'h0BEE);
        chk("loop12b_tde_cnt", {27'd0, rsp_tde_cnt}, 32'd8);

        // Payload bits above cmd_len are not sent
        issue(2'd1, 5'd4, 16'hFFF5);
        walk(32, 1, 16'h0005, 4, 1'b1, 0, 1'b0, bad, rises);
        chk("len4_waveform", bad, 0);
        @(negedge gclk);
        chk("len4_data",    {16'd0, rsp_data},    32'h0005);
        chk("len4_tde_cnt", {27'd0, rsp_tde_cnt}, 32'd4);
        loop_en = 1'b0;

        // IDLE_CLOCKS 40 with cmd_valid poked while busy
        issue(2'd2, 5'd0, 16'd40);
        walk(320, 2, 16'd0, 0, 1'b1, 0, 1'b1, bad, rises);
        chk("idle40_waveform", bad,   0);
        chk("idle40_rises",    rises, 40);
        @(negedge gclk);
        chk("idle40_valid", {31'd0, rsp_valid}, 32'd1);
        chk("idle40_err",   {31'd0, rsp_err},   32'd0);

        // Illegal commands and IDLE_CLOCKS 0, chained in DONE cycles
        issue(2'd3, 5'd8, 16'h1234);
        chk("op3_valid", {31'd0, rsp_valid}, 32'd1);
        chk("op3_err",   {31'd0, rsp_err},   32'd1);
        chk("op3_data",  {16'd0, rsp_data},  32'd0);
        chk("op3_pins",  {29'd0, tck, tdi, trstb}, 32'b001);
        issue(2'd1, 5'd0, 16'h00FF);
        chk("len0_valid", {31'd0, rsp_valid}, 32'd1);
        chk("len0_err",   {31'd0, rsp_err},   32'd1);
        chk("len0_pins",  {29'd0, tck, tdi, trstb}, 32'b001);
        issue(2'd1, 5'd17, 16'hFFFF);
        chk("len17_valid", {31'd0, rsp_valid}, 32'd1);
        chk("len17_err",   {31'd0, rsp_err},   32'd1);
        chk("len17_pins",  {29'd0, tck, tdi, trstb}, 32'b001);
        issue(2'd2, 5'd0, 16'd0);
        chk("idle0_valid", {31'd0, rsp_valid}, 32'd1);
        chk("idle0_err",   {31'd0, rsp_err},   32'd0);
        chk("idle0_tck",   {31'd0, tck},       32'd0);
        @(negedge gclk);

        // Reset pulse during bit 3 HIGH phase of a SHIFT
        issue(2'd1, 5'd8, 16'h00A5);
        walk(30, 1, 16'h00A5, 8, 1'b1, 0, 1'b0, bad, rises);
        chk("abort_pre_waveform", bad, 0);
        chk("abort_pre_tck", {31'd0, tck}, 32'd1);
        gclk_rstb = 1'b0;
        @(negedge gclk);
        chk("abort_pins",  {29'd0, tck, tdi, trstb}, 32'b000);
        chk("abort_valid", {31'd0, rsp_valid},       32'd0);
        chk("abort_ready", {31'd0, cmd_ready},       32'd0);
        gclk_rstb = 1'b1;
        @(negedge gclk);
        chk("abort_release_ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_valid", {31'd0, rsp_valid}, 32'd0);
            @(negedge gclk);
        end

        issue(2'd0, 5'd0, 16'd0);
        walk(64, 0, 16'd0, 0, 1'b0, 0, 1'b0, bad, rises);
        chk("reset2_window", bad, 0);
        @(negedge gclk);
        chk("reset2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("reset2_trstb", {31'd0, trstb},     32'd1);
        chk("reset2_err",   {31'd0, rsp_err},   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tap_driver.md
Name: tap_driver

Overview:
- Synthesizable TAP initiator. It is the hardware counterpart of the `tap` responder, for on-chip or tester-side use where no behavioural bench master exists.
- Takes word-level commands from a local controller over a valid/ready interface and serialises them onto tck/tdi/trstb.
- Captures tdo and tde back from the responder and returns them as a one-cycle response.
- Runs entirely on `gclk`; tck is a divided, fully synchronous output.

Parameters:
- CLK_DIV, 4: gclk cycles per tck half-period; legal values ≥1.
- RESET_CYCLES, 8: tck periods (2*CLK_DIV gclk each) that trstb is held low by a RESET command.

Ports:
- gclk  in  1  system clock; all logic on its rising edge
- gclk_rstb  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  driver idle, command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  0=RESET, 1=SHIFT, 2=IDLE_CLOCKS, 3=reserved
- cmd_len  in  5  SHIFT bit count, 1..16
- cmd_data  in  16  SHIFT payload (bit cmd_len-1 sent first) / IDLE_CLOCKS period count
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualified by rsp_valid; illegal op or length
- rsp_data  out  16  captured tdo bits, qualified by rsp_valid
- rsp_tde_cnt  out  5  number of SHIFT bits sampled with tde=1
- tck  out  1  TAP clock
- trstb  out  1  TAP reset, active low
- tdi  out  1  TAP serial data out
- tdo  in  1  TAP serial data in
- tde  in  1  responder data-valid flag

Behaviour:
- Clock/reset: one clock `gclk`; reset `gclk_rstb` is synchronous and active-low.
- Reset values:
  - tck=0, trstb=0, tdi=0, cmd_ready=0.
  - rsp_valid=0, rsp_err=0, rsp_data=0, rsp_tde_cnt=0.
  - State=IDLE.
  - cmd_ready rises the first cycle after reset release.
- trstb stays 0 after reset until the first RESET command completes; the responder stays in reset until commanded.
- States: IDLE, RST, LOW, HIGH, DONE.
- IDLE:
  - cmd_ready=1, tck=0, tdi=0.
  - On handshake (cycle 0), latch op/len/data, drop cmd_ready, clear rsp_data and rsp_tde_cnt.
  - Cleared rsp_data/rsp_tde_cnt stay stable until the next response.
- RESET: trstb=0, tck=0 for cycles 1..2*CLK_DIV*RESET_CYCLES. In the next cycle trstb=1 and the block enters DONE.
- SHIFT, per bit k (k=0 first, bit index cmd_len-1-k):
  - LOW: CLK_DIV cycles, tck=0, tdi=bit, set at the first LOW cycle.
  - HIGH: CLK_DIV cycles, tck=1, tdi held.
  - In the last HIGH cycle, sample tdo into the rsp_data LSB (shift left) and add tde to rsp_tde_cnt.
  - After N bits, rsp_data[N-1:0] holds the captured stream, first bit in bit N-1; upper bits are 0.
- IDLE_CLOCKS:
  - cmd_data periods of LOW/HIGH with tdi=0 and no sampling.
  - A count of 0 goes directly to DONE.
  - Used for OPCG execute windows.
- Latency:
  - The last HIGH phase ends at cycle 2*CLK_DIV*N.
  - DONE is cycle 2*CLK_DIV*N+1: tck=0, tdi=0, rsp_valid=1, cmd_ready=1.
  - A new handshake is allowed in the DONE cycle.
- Errors: the following give rsp_valid=1, rsp_err=1 in cycle 1, with no pin activity and rsp_data=0:
  - op=3;
  - SHIFT with cmd_len=0;
  - SHIFT with cmd_len>16.
- rsp_err=0 for all legal completions.
- cmd_valid while busy is ignored. cmd_* inputs are don't-care outside the handshake.
- tck never glitches: it changes only on phase boundaries. tck and tdi never change in the same cycle except at the first LOW cycle, where tck is already 0.
- trstb is unaffected by SHIFT and IDLE_CLOCKS.
- gclk_rstb low in any state: immediate return to reset values next edge; the in-flight command is aborted and produces no rsp_valid.
- Counters:
  - phase counter ≥ clog2(CLK_DIV) bits;
  - bit counter 5 bits;
  - period counter 16 bits.
  - No wrap: each terminates on equality.

Test Plan:
- Reset/RESET op (CLK_DIV=4, RESET_CYCLES=8): release gclk_rstb → trstb=0, cmd_ready=1 one cycle later. RESET → trstb low cycles 1..64, trstb=1 and rsp_valid at cycle 65, tck=0 throughout.
- SHIFT len=8 data=0x0096 → tdi sequence 1,0,0,1,0,1,1,0, each held 8 gclk; 8 tck pulses, high during cycles 5-8, 13-16, …; rsp_valid at cycle 65, rsp_err=0.
- Loopback tdo=tdi with tde=1, SHIFT len=12 data=0x0BEE → rsp_data=0x0BEE, rsp_tde_cnt=12. Repeat with tde=0 for the first 4 bits → rsp_tde_cnt=8.
- IDLE_CLOCKS data=40 → exactly 40 tck pulses, tdi=0, rsp_valid at cycle 321. data=0 → rsp_valid at cycle 1, no tck edge.
- Illegal: op=3, and SHIFT len=0 → rsp_valid+rsp_err at cycle 1, pins static. Back-to-back handshake in the DONE cycle is accepted with no idle gap.
- gclk_rstb pulsed low mid-SHIFT (bit 3, HIGH phase) → next edge tck=0, trstb=0, tdi=0, no rsp_valid. After release, cmd_ready=1 and a new RESET completes normally.
